dmem_responder: RTL
===================

# dmem_responder

Memory-side responder for the core's M-stage data port: services `memwriteM`/`aluoutM`/`writedataM` and returns `readdataM`. It holds word-addressed data RAM plus a small MMIO window with a free-running cycle counter, an LED register, a sticky status register and a mailbox FIFO. The FIFO drains to the host over a valid/ready handshake. The block sits beside each core in the multicore top, on the opposite end of the core's data-memory interface.

## Interface

- `ADDR_W`, 6, RAM word-address width (RAM depth = 2^ADDR_W words)
- `FIFO_DEPTH`, 4, mailbox entries (power of 2, ≤ 8)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `memwriteM`  in  1  core write strobe
- `aluoutM`  in  32  core byte address
- `writedataM`  in  32  core write data
- `readdataM`  out  32  read data, combinational from `aluoutM`
- `led_out`  out  32  LED register contents
- `mbox_valid`  out  1  FIFO head valid toward host
- `mbox_data`  out  32  FIFO head word (0 when empty)
- `mbox_ready`  in  1  host accepts head word

## Operation

- Address decode, in priority order:
  - **MMIO:** `aluoutM[31:8]==24'hFFFFFF`; offset = `aluoutM[7:0]`.
  - **RAM:** `aluoutM[31:ADDR_W+2]==0`; index = `aluoutM[ADDR_W+1:2]`.
  - **Out of bounds:** everything else. Read returns 0, write ignored, sets status bit 1 (OOB).
- **Misaligned** (`aluoutM[1:0]!=0`) in any region:
  - Read uses the aligned word.
  - Write is ignored and sets status bit 0 (MISALIGN).
- **MMIO offsets:**
  - 0x00 CYCLES: RO. 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF→0.
  - 0x04 LED: RW. Drives `led_out`.
  - 0x08 STATUS: read gives {25'b0, count[2:0], 1'b0, OVF, OOB, MISALIGN}. Writing 1 to bits [2:0] clears them (W1C); a write of 0 has no effect.
  - 0x0C MBOX: write pushes `writedataM`; read returns 0.
  - Any other offset reads 0 and ignores writes. It does not set OOB.
- **Mailbox FIFO:**
  - Push on MBOX write; pop when `mbox_valid && mbox_ready`.
  - Push while full with no pop in the same cycle: word dropped, OVF set.
  - Push while full with a pop in the same cycle: both occur, count unchanged, no OVF.
  - Push while empty: word appears at head the next cycle. No bypass.
- **Error-flag priority:** if a sticky set and a W1C clear of the same bit occur in the same cycle, set wins.
- **RAM:** not reset; contents are undefined until written.

## Timing

- Reads have zero latency. `readdataM` follows `aluoutM` combinationally.
- Read-during-write to the same RAM word returns the old data in that cycle and the new data afterwards.
- RAM, LED, STATUS and FIFO writes commit on the rising edge where `memwriteM=1`.
- CYCLES reads show the pre-edge value. On the first cycle after reset release the read returns 0.
- `mbox_valid`/`mbox_data` are registered-state outputs. They are valid one cycle after the push edge.
- Reset (async assert, any time including mid-transfer) forces:
  - CYCLES=0, `led_out`=0, STATUS=0
  - FIFO empty, so `mbox_valid`=0 and `mbox_data`=0
- A host handshake in flight during reset is discarded.

## Structure

- Package `mips_mem_pkg` holds:
  - MMIO base `24'hFFFFFF`
  - offset constants `OFF_CYCLES`/`OFF_LED`/`OFF_STATUS`/`OFF_MBOX`
  - STATUS bit indices
  - a region-decode enum {REG_RAM, REG_MMIO, REG_OOB}
- One sub-module, `mbox_fifo`:
  - parameterised depth
  - push/full/overflow in
  - valid/ready/data out
  - count
- The top holds decode, RAM array, counter, LED and STATUS.

## Test plan

- **RAM and read-during-write:** write 0xDEADBEEF to 0x00000010, then read 0x00000010 → `readdataM`=0xDEADBEEF. Read-during-write of 0x12345678 to the same address → that cycle reads 0xDEADBEEF, next cycle 0x12345678.
- **Misaligned and OOB:**
  - Write to 0x00000011 → RAM unchanged, STATUS=0x1.
  - Write to 0x00001000 with ADDR_W=6 → STATUS=0x3; read 0x00001000 → 0.
  - Write 0x3 to 0xFFFFFF08 → STATUS=0x0.
- **Counter:** release reset, read 0xFFFFFF00 on cycles 0 and 10 → 0 and 10. Force the counter to 0xFFFFFFFF → next cycle reads 0.
- **Mailbox and overflow:**
  - Hold `mbox_ready`=0, push 1..5 → STATUS count=4, OVF=1.
  - Raise ready → host receives 1,2,3,4 in order, then `mbox_valid`=0.
- **Full with simultaneous push/pop:** at count=4 with ready=1, push 9 → count stays 4, OVF=0, 9 is delivered last.
- **Reset mid-operation:** with LED=0xA5 and FIFO count 3, assert `rst`=0 asynchronously → `led_out`=0, `mbox_valid`=0, STATUS=0 immediately, before the next edge.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared constants and decode helpers for the core-side data-memory responder.
// Holds the MMIO window map, STATUS bit positions and the address-region decode.
package mips_mem_pkg;

  localparam logic [23:0] MMIO_BASE  = 24'hFFFFFF;

  localparam logic [7:0]  OFF_CYCLES = 8'h00;
  localparam logic [7:0]  OFF_LED    = 8'h04;
  localparam logic [7:0]  OFF_STATUS = 8'h08;
  localparam logic [7:0]  OFF_MBOX   = 8'h0C;

  localparam int ST_MISALIGN = 0;
  localparam int ST_OOB      = 1;
  localparam int ST_OVF      = 2;

  typedef enum logic [1:0] {REG_RAM, REG_MMIO, REG_OOB} region_e;

  // MMIO takes priority over RAM; anything outside both is out of bounds.
  function automatic region_e decode_region(input logic [31:0] addr, input int addr_w);
    if (addr[31:8] == MMIO_BASE) return REG_MMIO;
    if ((addr >> (addr_w + 2)) == 32'd0) return REG_RAM;
    return REG_OOB;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core data-port bus plus the host-facing mailbox handshake.
// The core/host side uses master; the responder uses slave.
interface dmem_responder_if;
  logic        memwriteM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic [31:0] readdataM;
  logic        mbox_valid;
  logic [31:0] mbox_data;
  logic        mbox_ready;

  modport master (
    output memwriteM, aluoutM, writedataM, mbox_ready,
    input  readdataM, mbox_valid, mbox_data
  );

  modport slave (
    input  memwriteM, aluoutM, writedataM, mbox_ready,
    output readdataM, mbox_valid, mbox_data
  );
endinterface

// File: rtl/mbox_fifo.sv
// Mailbox FIFO: a push while full is dropped and flagged unless a pop frees a slot
// in the same cycle. The head word reads as 0 when the FIFO is empty.
module mbox_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [31:0] push_data,
  output logic        ovf,
  output logic        valid,
  input  logic        ready,
  output logic [31:0] data,
  output logic [2:0]  count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full, pop, do_push;

  always_comb begin
    full     = cnt_q == CNT_W'(DEPTH);
    valid    = cnt_q != '0;
    pop      = valid && ready;
    do_push  = push && (!full || pop);
    ovf      = push && full && !pop;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(pop);
    data     = valid ? mem[rd_ptr_q] : '0;
    count    = 3'(cnt_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset; the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's M-stage data port: word RAM plus an MMIO
// window holding a cycle counter, LED register, sticky STATUS and the mailbox.
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus,
  output logic [31:0]     led_out
);
  logic [31:0]       cycles_q, cycles_d;
  logic [31:0]       led_q, led_d;
  logic [2:0]        err_q, err_d, err_set;
  logic [31:0]       ram [2**ADDR_W];
  region_e           region;
  logic              misalign, wr_ok, ram_we, led_we, status_wr, mbox_push;
  logic              fifo_ovf;
  logic [2:0]        fifo_count;
  logic [7:0]        offset;
  logic [ADDR_W-1:0] ram_idx;
  logic [31:0]       rdata;

  // Kept as a continuous assignment so the next-count value is a plain net.
  assign cycles_d = cycles_q + 32'd1;

  always_comb begin
    region    = decode_region(bus.aluoutM, ADDR_W);
    misalign  = bus.aluoutM[1:0] != 2'b00;
    offset    = {bus.aluoutM[7:2], 2'b00};
    ram_idx   = bus.aluoutM[ADDR_W+1:2];
    wr_ok     = bus.memwriteM && !misalign;
    ram_we    = wr_ok && (region == REG_RAM);
    led_we    = wr_ok && (region == REG_MMIO) && (offset == OFF_LED);
    status_wr = wr_ok && (region == REG_MMIO) && (offset == OFF_STATUS);
    mbox_push = wr_ok && (region == REG_MMIO) && (offset == OFF_MBOX);
    led_d     = led_we ? bus.writedataM : led_q;

    err_set              = '0;
    err_set[ST_MISALIGN] = bus.memwriteM && misalign;
    err_set[ST_OOB]      = bus.memwriteM && (region == REG_OOB);
    err_set[ST_OVF]      = fifo_ovf;
  end

  // Sticky flags: a set in the same cycle as a W1C clear wins.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_err
      assign err_d[gi] = err_set[gi] | (err_q[gi] & ~(status_wr & bus.writedataM[gi]));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycles_q <= '0;
      led_q    <= '0;
      err_q    <= '0;
    end else begin
      cycles_q <= cycles_d;
      led_q    <= led_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= bus.writedataM;
  end

  always_comb begin
    rdata = '0;
    case (region)
      REG_RAM: rdata = ram[ram_idx];
      REG_MMIO: begin
        case (offset)
          OFF_CYCLES: rdata = cycles_q;
          OFF_LED:    rdata = led_q;
          OFF_STATUS: rdata = {25'b0, fifo_count, 1'b0,
                               err_q[ST_OVF], err_q[ST_OOB], err_q[ST_MISALIGN]};
          default:    rdata = '0;
        endcase
      end
      default: rdata = '0;
    endcase
  end

  assign bus.readdataM = rdata;
  assign led_out       = led_q;

  mbox_fifo #(.DEPTH(FIFO_DEPTH)) u_mbox (
    .clk       (clk),
    .rst       (rst),
    .push      (mbox_push),
    .push_data (bus.writedataM),
    .ovf       (fifo_ovf),
    .valid     (bus.mbox_valid),
    .ready     (bus.mbox_ready),
    .data      (bus.mbox_data),
    .count     (fifo_count)
  );

endmodule
